// File: rtl/dram_cache_pkg.sv
// Shared types and helpers for the DRAM request-FIFO write arbiter.
package dram_cache_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_BURST
  } arb_state_t;

  // Fold an index that may have run one lap past n back into [0, n-1].
  function automatic int unsigned wrap_idx(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set bit of req at or after rr_ptr, wrapping to index 0.
module rr_picker
  import dram_cache_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     off;

  always_comb begin
    // Rotate so rr_ptr lands at bit 0, encode lowest set bit, then rotate back.
    dbl = {req, req} >> rr_ptr;
    rot = dbl[NUM_REQ-1:0];
    any = |req;
    off = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    idx = IDX_W'(wrap_idx(32'(rr_ptr) + 32'(off), NUM_REQ));
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter in front of a shared FIFO write port, with
// zero-latency handshake and full / almost-full backpressure.
module fifo_write_arbiter
  import dram_cache_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_BIT_SIZE = 8,
  parameter int unsigned MAX_BURST     = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_last,
  input  logic [NUM_REQ*DATA_BIT_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic                             fifo_full,
  input  logic                             fifo_A_full,
  output logic                             fifo_write_en,
  output logic [DATA_BIT_SIZE-1:0]         fifo_write_data,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic                             busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_t         state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [CNT_W-1:0]   beat_cnt_q;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] xfer;

  function automatic logic [IDX_W-1:0] next_of(input logic [IDX_W-1:0] i);
    return IDX_W'(wrap_idx(32'(i) + 32'd1, NUM_REQ));
  endfunction

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    busy      = 1'b0;
    if (!reset) begin
      if (state_q == ARB_BURST) begin
        // Almost-full is ignored here so a started burst drains into the slack.
        grant_id          = owner_q;
        req_ready[owner_q] = ~fifo_full;
        busy              = 1'b1;
      end else begin
        grant_id = pick_idx;
        if (!fifo_A_full && pick_any) req_ready[pick_idx] = ~fifo_full;
      end
    end
  end

  always_comb begin
    xfer            = req_valid & req_ready;
    fifo_write_en   = |xfer;
    fifo_write_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (xfer[i]) fifo_write_data = req_data[i*DATA_BIT_SIZE +: DATA_BIT_SIZE];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else if (fifo_write_en) begin
      case (state_q)
        ARB_IDLE: begin
          if (req_last[pick_idx] || (MAX_BURST == 1)) begin
            rr_ptr_q <= next_of(pick_idx);
          end else begin
            state_q    <= ARB_BURST;
            owner_q    <= pick_idx;
            beat_cnt_q <= CNT_W'(1);
          end
        end
        ARB_BURST: begin
          if (req_last[owner_q] || (beat_cnt_q == LAST_BEAT)) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= next_of(owner_q);
            beat_cnt_q <= '0;
          end else begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter driving a behavioural 8-deep FIFO (A_full at 6).
module tb_fifo_write_arbiter;

  localparam int NR         = 4;
  localparam int W          = 8;
  localparam int FIFO_SIZE  = 8;
  localparam int A_FULL_THR = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid, req_last, req_ready;
  logic [NR*W-1:0] req_data;
  logic            fifo_full, fifo_A_full, fifo_write_en;
  logic [W-1:0]    fifo_write_data;
  logic [1:0]      grant_id;
  logic            busy;

  logic [W-1:0]    dw [NR];
  logic            rd_en;
  int              checks = 0, failures = 0, n_exp = 0, n_wr = 0;
  logic [W+1:0]    exp_q[$];
  logic [W-1:0]    rdx_q[$];
  logic [W-1:0]    fifo_q[$];
  int              fifo_cnt = 0;
  logic            we_s = 1'b0, rd_s = 1'b0;
  logic [W-1:0]    wd_s = '0;
  logic [W+1:0]    e;
  logic [W-1:0]    rd_word;

  fifo_write_arbiter #(
    .NUM_REQ       (NR),
    .DATA_BIT_SIZE (W),
    .MAX_BURST     (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_last        (req_last),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .fifo_full       (fifo_full),
    .fifo_A_full     (fifo_A_full),
    .fifo_write_en   (fifo_write_en),
    .fifo_write_data (fifo_write_data),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = dw[i];
  end

  assign fifo_full   = (fifo_cnt >= FIFO_SIZE);
  assign fifo_A_full = (fifo_cnt >= A_FULL_THR);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write-side monitor: every FIFO write must match the next queued expectation.
  always @(negedge clk) begin
    we_s = fifo_write_en;
    wd_s = fifo_write_data;
    rd_s = rd_en;
    if (fifo_full) chk("no_write_when_full", 32'(fifo_write_en), 32'd0);
    if (fifo_write_en) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got data %0h id %0d expected no write at %0t",
                 fifo_write_data, grant_id, $time);
      end else begin
        e = exp_q.pop_front();
        chk("grant_id", 32'(grant_id), 32'(e[W+1:W]));
        chk("write_data", 32'(fifo_write_data), 32'(e[W-1:0]));
      end
    end
  end

  // FIFO model; count updated with <= so the DUT samples the pre-edge status.
  always @(posedge clk) begin
    if (rd_s && fifo_q.size() > 0) begin
      rd_word = fifo_q.pop_front();
      if (rdx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL read_order: got %0h expected nothing at %0t", rd_word, $time);
      end else begin
        chk("read_order", 32'(rd_word), 32'(rdx_q.pop_front()));
      end
    end
    if (we_s) fifo_q.push_back(wd_s);
    fifo_cnt <= fifo_q.size();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: optional expected write from id, plus expected ready vector and busy.
  task automatic cyc(input bit w, input int id, input logic [NR-1:0] rdy, input bit bsy);
    if (w) begin
      exp_q.push_back({2'(id), dw[id]});
      rdx_q.push_back(dw[id]);
      n_exp++;
    end
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(rdy));
    chk("busy", 32'(busy), 32'(bsy));
    if (!w) chk("stall_no_write", 32'(fifo_write_en), 32'd0);
    tick();
    if (w) dw[id] = dw[id] + 8'd1;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) dw[i] = 8'(i << 6);
    reset     = 1'b1;
    req_valid = 4'hF;
    req_last  = 4'hF;
    rd_en     = 1'b1;

    // Reset: outputs gated to zero even with all requesters valid.
    @(negedge clk);
    chk("rst_data", 32'(fifo_write_data), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    tick();
    cyc(0, 0, 4'b0000, 0);
    cyc(0, 0, 4'b0000, 0);

    // All valid, single-word bursts: 0,1,2,3,0.
    reset = 1'b0;
    cyc(1, 0, 4'b0001, 0);
    cyc(1, 1, 4'b0010, 0);
    cyc(1, 2, 4'b0100, 0);
    cyc(1, 3, 4'b1000, 0);
    cyc(1, 0, 4'b0001, 0);

    // Req 1 bursts to MAX_BURST, req 0 locked out, then wrap gives req 0.
    req_valid = 4'b0011;
    req_last  = 4'b0001;
    cyc(1, 1, 4'b0010, 0);
    cyc(1, 1, 4'b0010, 1);
    cyc(1, 1, 4'b0010, 1);
    cyc(1, 1, 4'b0010, 1);
    cyc(1, 0, 4'b0001, 0);

    // Owner 0 drops valid for 3 cycles; req 1 must stay blocked.
    req_valid = 4'b0001;
    req_last  = 4'b0000;
    cyc(1, 0, 4'b0001, 0);
    cyc(1, 0, 4'b0001, 1);
    req_valid = 4'b0010;
    cyc(0, 0, 4'b0001, 1);
    cyc(0, 0, 4'b0001, 1);
    cyc(0, 0, 4'b0001, 1);
    req_valid = 4'b0011;
    cyc(1, 0, 4'b0001, 1);
    cyc(1, 0, 4'b0001, 1);
    req_last = 4'b0010;
    cyc(1, 1, 4'b0010, 0);

    // Reset mid-burst (owner 2, two beats in); partial burst is dropped.
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    cyc(1, 2, 4'b0100, 0);
    cyc(1, 2, 4'b0100, 1);
    reset = 1'b1;
    cyc(0, 0, 4'b0000, 0);
    reset     = 1'b0;
    req_valid = 4'b0110;
    req_last  = 4'b0110;
    cyc(1, 1, 4'b0010, 0);
    req_valid = 4'b0000;
    cyc(0, 0, 4'b0000, 0);
    cyc(0, 0, 4'b0000, 0);

    // Fill FIFO to 6 with reads stopped; A_full then blocks a new grant.
    rd_en     = 1'b0;
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    for (int k = 0; k < 6; k++) cyc(1, 0, 4'b0001, 0);
    req_valid = 4'b1000;
    req_last  = 4'b0000;
    cyc(0, 0, 4'b0000, 0);

    // Drop to 5, start a burst that runs through A_full into full.
    rd_en     = 1'b1;
    req_valid = 4'b0000;
    cyc(0, 0, 4'b0000, 0);
    rd_en     = 1'b0;
    req_valid = 4'b1000;
    cyc(1, 3, 4'b1000, 0);
    cyc(1, 3, 4'b1000, 1);
    cyc(1, 3, 4'b1000, 1);
    cyc(0, 0, 4'b0000, 1);
    rd_en = 1'b1;
    cyc(0, 0, 4'b0000, 1);
    rd_en = 1'b0;
    cyc(1, 3, 4'b1000, 1);

    // Drain and settle.
    rd_en     = 1'b1;
    req_valid = 4'b0000;
    for (int k = 0; k < 10; k++) cyc(0, 0, 4'b0000, 0);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("read_q_empty", 32'(rdx_q.size()), 32'd0);
    chk("write_count", 32'(n_wr), 32'(n_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
